// File: rtl/ram_port_arbiter_pkg.sv
// Shared SoC definitions for the CPU/VGA single-port RAM arbiter:
// FSM state encoding and the default CPU run limit.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISS_CPU = 2'd1,
    ISS_VGA = 2'd2
  } arb_state_e;

  localparam int CPU_RUN_MAX_DEFAULT = 4;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for one synchronous RAM port: CPU has priority, but the
// display side is guaranteed a slot after CPU_RUN_MAX CPU grants while it waits.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW          = 10,
  parameter int DW          = 32,
  parameter int CPU_RUN_MAX = CPU_RUN_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  localparam int            RW      = $clog2(CPU_RUN_MAX + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(CPU_RUN_MAX);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [RW-1:0] run_q, run_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          vga_rvalid_q, vga_rvalid_d;
  logic [DW-1:0] vga_rdata_q, vga_rdata_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      run_q        <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      run_q        <= run_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    run_d        = run_q;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    vga_rvalid_d = 1'b0;
    vga_rdata_d  = vga_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (!vga_req) begin
          run_d = '0;
        end
        // VGA only overrides a pending CPU request once the CPU run is used up.
        if (cpu_req && !(vga_req && (run_q == RUN_MAX))) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = ISS_CPU;
        end else if (vga_req) begin
          addr_d  = vga_addr;
          we_d    = 1'b0;
          state_d = ISS_VGA;
        end
      end
      ISS_CPU: begin
        if (vga_req && (run_q != RUN_MAX)) begin
          run_d = run_q + RW'(1);
        end
        if (!we_q) begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = ram_dout;
        end
        state_d = IDLE;
      end
      ISS_VGA: begin
        run_d        = '0;
        vga_rvalid_d = 1'b1;
        vga_rdata_d  = ram_dout;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_gnt    = (state_q == ISS_CPU);
  assign vga_gnt    = (state_q == ISS_VGA);
  assign busy       = (state_q != IDLE);
  assign ram_addr   = addr_q;
  assign ram_din    = wdata_q;
  // Gating with rst kills a write that coincides with a reset edge.
  assign ram_we     = (state_q == ISS_CPU) && we_q && rst;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vga_rvalid = vga_rvalid_q;
  assign vga_rdata  = vga_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by a
// randomized phase, all checked against a queue-based transaction model.
module tb_ram_port_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RUNMAX = 4;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt, vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          busy;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW), .CPU_RUN_MAX(RUNMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy)
  );

  function automatic logic [DW-1:0] initWord(input int a);
    return 32'hA5A5_0000 ^ DW'(a * 7919);
  endfunction

  // RAM behind the port: contents valid at the edge closing the address cycle.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          memReady = 1'b0;
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initWord(i);
      memReady <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } txn_t;

  typedef enum {GN_NONE, GN_CPU, GN_VGA} who_e;

  txn_t          cpuQ[$], vgaQ[$];
  txn_t          cpuCur, vgaCur;
  bit            cpuActive, vgaActive;
  who_e          grantNow, prevGrant;
  int            streak;
  logic [DW-1:0] refMem [0:DEPTH-1];
  logic          expCpuRvalid, expVgaRvalid;
  logic [DW-1:0] expCpuRdata, expVgaRdata;
  logic [AW-1:0] expAddr;
  string         gntLog, rvLog, weLog;
  int            assertCount, failCount;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkLog(input string tag, input string observed, input string expected);
    assertCount++;
    assert (observed == expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed \"%s\", expected \"%s\"", tag, observed, expected);
    end
  endtask

  function automatic txn_t randTxn(input bit isCpu);
    txn_t t;
    t.we   = isCpu ? 1'($urandom_range(0, 1)) : 1'b0;
    t.addr = AW'($urandom_range(0, 15));
    t.data = $urandom;
    t.gap  = int'($urandom_range(0, 3));
    return t;
  endfunction

  // Requesters hold each transaction until the model says it was granted.
  task automatic applyStimulus(input logic rstVal);
    txn_t t;
    rst = rstVal;
    if (prevGrant == GN_CPU) cpuActive = 0;
    if (prevGrant == GN_VGA) vgaActive = 0;
    if (!rstVal) begin
      cpuActive = 0;
      vgaActive = 0;
    end else begin
      if (!cpuActive && cpuQ.size() > 0) begin
        if (cpuQ[0].gap > 0) begin
          t = cpuQ[0]; t.gap--; cpuQ[0] = t;
        end else begin
          cpuCur = cpuQ.pop_front(); cpuActive = 1;
        end
      end
      if (!vgaActive && vgaQ.size() > 0) begin
        if (vgaQ[0].gap > 0) begin
          t = vgaQ[0]; t.gap--; vgaQ[0] = t;
        end else begin
          vgaCur = vgaQ.pop_front(); vgaActive = 1;
        end
      end
    end
    cpu_req   = cpuActive;
    cpu_we    = cpuCur.we;
    cpu_addr  = cpuCur.addr;
    cpu_wdata = cpuCur.data;
    vga_req   = vgaActive;
    vga_addr  = vgaCur.addr;
  endtask

  task automatic updateModel(input logic rstVal);
    if (!rstVal) begin
      grantNow = GN_NONE; prevGrant = GN_NONE; streak = 0;
      expCpuRvalid = 0; expVgaRvalid = 0; expCpuRdata = '0; expVgaRdata = '0;
      expAddr = '0; cpuQ.delete(); vgaQ.delete(); cpuActive = 0; vgaActive = 0;
      return;
    end
    expCpuRvalid = 0;
    expVgaRvalid = 0;
    if (grantNow == GN_CPU) begin
      if (cpuCur.we) refMem[cpuCur.addr] = cpuCur.data;
      else begin expCpuRvalid = 1; expCpuRdata = refMem[cpuCur.addr]; end
      if (vgaActive && streak < RUNMAX) streak++;
    end else if (grantNow == GN_VGA) begin
      expVgaRvalid = 1;
      expVgaRdata  = refMem[vgaCur.addr];
      streak = 0;
    end
    prevGrant = grantNow;
    // Grants alternate with free arbitration cycles.
    if (grantNow != GN_NONE) grantNow = GN_NONE;
    else begin
      if (!vgaActive) streak = 0;
      if (cpuActive && !(vgaActive && streak == RUNMAX)) begin
        grantNow = GN_CPU; expAddr = cpuCur.addr;
      end else if (vgaActive) begin
        grantNow = GN_VGA; expAddr = vgaCur.addr;
      end
    end
  endtask

  task automatic runCycle(input logic rstVal);
    applyStimulus(rstVal);
    #4;
    checkOutput("cpu_gnt", DW'(cpu_gnt), DW'(grantNow == GN_CPU));
    checkOutput("vga_gnt", DW'(vga_gnt), DW'(grantNow == GN_VGA));
    checkOutput("busy", DW'(busy), DW'(grantNow != GN_NONE));
    checkOutput("ram_we", DW'(ram_we), DW'((grantNow == GN_CPU) && cpuCur.we && rstVal));
    checkOutput("ram_addr", DW'(ram_addr), DW'(expAddr));
    if (grantNow == GN_CPU) checkOutput("ram_din", ram_din, cpuCur.data);
    checkOutput("cpu_rvalid", DW'(cpu_rvalid), DW'(expCpuRvalid));
    checkOutput("vga_rvalid", DW'(vga_rvalid), DW'(expVgaRvalid));
    checkOutput("cpu_rdata", cpu_rdata, expCpuRdata);
    checkOutput("vga_rdata", vga_rdata, expVgaRdata);
    if (cpu_gnt === 1'b1) gntLog = {gntLog, "C"};
    else if (vga_gnt === 1'b1) gntLog = {gntLog, "V"};
    else gntLog = {gntLog, "."};
    if (cpu_rvalid === 1'b1) rvLog = {rvLog, "c"};
    else if (vga_rvalid === 1'b1) rvLog = {rvLog, "v"};
    else rvLog = {rvLog, "."};
    if (ram_we === 1'b1) weLog = {weLog, "W"};
    else weLog = {weLog, "."};
    updateModel(rstVal);
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    gntLog = ""; rvLog = ""; weLog = "";
  endtask

  initial begin
    assertCount = 0; failCount = 0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    cpuCur = '{1'b0, '0, '0, 0}; vgaCur = '{1'b0, '0, '0, 0};
    cpuActive = 0; vgaActive = 0; grantNow = GN_NONE; prevGrant = GN_NONE; streak = 0;
    expCpuRvalid = 0; expVgaRvalid = 0; expCpuRdata = '0; expVgaRdata = '0; expAddr = '0;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    clearLogs();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    runCycle(1'b0);

    $display("[TB] CPU write then read of 0x05");
    clearLogs();
    cpuQ.push_back('{1'b1, 10'h005, 32'h1234_5678, 0});
    cpuQ.push_back('{1'b0, 10'h005, 32'h0, 0});
    repeat (6) runCycle(1'b1);
    checkLog("wr_rd_gnt", gntLog, ".C.C..");
    checkLog("wr_rd_we", weLog, ".W....");
    checkLog("wr_rd_rvalid", rvLog, "....c.");
    checkOutput("wr_rd_data", cpu_rdata, 32'h1234_5678);

    $display("[TB] lone VGA read of 0x3FF");
    clearLogs();
    vgaQ.push_back('{1'b0, 10'h3FF, 32'h0, 0});
    repeat (4) runCycle(1'b1);
    checkLog("vga_gnt_seq", gntLog, ".V..");
    checkLog("vga_rvalid_seq", rvLog, "..v.");
    checkLog("vga_no_we", weLog, "....");
    checkOutput("vga_data", vga_rdata, initWord(10'h3FF));

    $display("[TB] both requesters held continuously");
    clearLogs();
    for (int i = 0; i < 8; i++) cpuQ.push_back('{1'b0, AW'(i), 32'h0, 0});
    vgaQ.push_back('{1'b0, 10'h3FE, 32'h0, 0});
    vgaQ.push_back('{1'b0, 10'h3FD, 32'h0, 0});
    repeat (21) runCycle(1'b1);
    checkLog("fair_order", gntLog, ".C.C.C.C.V.C.C.C.C.V.");

    $display("[TB] simultaneous first requests");
    clearLogs();
    cpuQ.push_back('{1'b0, 10'h010, 32'h0, 0});
    vgaQ.push_back('{1'b0, 10'h011, 32'h0, 0});
    repeat (5) runCycle(1'b1);
    checkLog("simul_gnt", gntLog, ".C.V.");
    checkLog("simul_rvalid", rvLog, "..c.v");

    $display("[TB] reset during CPU write grant");
    clearLogs();
    cpuQ.push_back('{1'b1, 10'h020, 32'hDEAD_BEEF, 0});
    runCycle(1'b1);
    runCycle(1'b0);
    runCycle(1'b1);
    checkLog("rst_wr_we", weLog, "...");
    checkOutput("rst_mem_kept", mem[32], initWord(32));

    $display("[TB] reset during CPU read grant");
    clearLogs();
    cpuQ.push_back('{1'b0, 10'h005, 32'h0, 0});
    runCycle(1'b1);
    runCycle(1'b0);
    runCycle(1'b1);
    checkLog("rst_rd_rvalid", rvLog, "...");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      if (cpuQ.size() < 2) cpuQ.push_back(randTxn(1'b1));
      if (vgaQ.size() < 2) vgaQ.push_back(randTxn(1'b0));
      runCycle((n == 200) ? 1'b0 : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
